aud_xport_ctrl: RTL and testbench

- Parametrised transport controller for the audio recorder/player. Sequences codec I2C init, then arbitrates record/play/pause/stop from three push keys.
- Adds multi-slot SRAM partitioning, per-slot recorded-length tracking, auto-stop at end of recording or region full, and latched speed/interpolation mode.
- Drives start/pause/stop pulses to the recorder, DSP and player, plus the SRAM-direction select.

---
 rtl/aud_xport_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_aud_xport_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_xport_ctrl.sv
// aud_xport_ctrl: codec init, then record/play/pause/stop transport sequencing.
// Define AUD_XPORT_TIMER_EN to build the elapsed-seconds counter on o_time_sec.
module aud_xport_ctrl #(
   parameter int ADDR_W      = 20,
   parameter int NUM_SLOTS   = 4,
   parameter int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   parameter int SPEED_MAX   = 8,
   parameter int CLK_PER_SEC = 12000000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_key_rec,
   input  logic              i_key_play,
   input  logic              i_key_stop,
   input  logic [SLOT_W-1:0] i_slot_sel,
   input  logic [3:0]        i_speed,
   input  logic              i_fast,
   input  logic              i_interp,
   input  logic              i_i2c_fin,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [ADDR_W-1:0] i_play_addr,
   output logic              o_i2c_start,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_play_start,
   output logic              o_play_pause,
   output logic              o_play_stop,
   output logic              o_play_en,
   output logic              o_rec_active,
   output logic [ADDR_W-1:0] o_base_addr,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic [3:0]        o_speed,
   output logic              o_fast,
   output logic              o_slow_linear,
   output logic [2:0]        o_state,
   output logic [5:0]        o_time_sec
);

   localparam int RW = ADDR_W - SLOT_W;
   localparam logic [ADDR_W-1:0] REG_LAST = {{SLOT_W{1'b0}}, {RW{1'b1}}};
   localparam logic [SLOT_W-1:0] SLOT_MSK = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [3:0]        SPD_MAX  = 4'(SPEED_MAX);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_RECD   = 3'd2,
      S_RECD_P = 3'd3,
      S_PLAY   = 3'd4,
      S_PLAY_P = 3'd5
   } state_t;

   state_t            state_q, state_n;
   logic              key_rec_q, key_play_q, key_stop_q;
   logic              rec_e, play_e, stop_e;
   logic              i2c_sent_q;
   logic [SLOT_W-1:0] slot_q, slot_m;
   logic [ADDR_W-1:0] base_q, end_q, base_d, len_sel;
   logic [ADDR_W-1:0] len_q [NUM_SLOTS];
   logic [3:0]        spd_c;
   logic              i2c_n, rs_n, rp_n, rt_n, ps_n, pp_n, pt_n;
   logic              lat_rec, lat_play, lat_mode, len_we;

   assign rec_e   = i_key_rec  & ~key_rec_q;
   assign play_e  = i_key_play & ~key_play_q;
   assign stop_e  = i_key_stop & ~key_stop_q;
   assign slot_m  = i_slot_sel & SLOT_MSK;
   assign base_d  = {slot_m, {RW{1'b0}}};
   assign len_sel = len_q[slot_m];

   assign o_base_addr = base_q;
   assign o_end_addr  = end_q;
   assign o_state     = state_q;

   always_comb begin
      spd_c = i_speed;
      if (i_speed == 4'd0)
         spd_c = 4'd1;
      else if (i_speed > SPD_MAX)
         spd_c = SPD_MAX;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= S_INIT;
      else
         state_q <= state_n;
   end

   // Stop (manual or automatic) always outranks pause/resume in a state.
   always_comb begin
      state_n  = state_q;
      i2c_n    = 1'b0;
      rs_n     = 1'b0;
      rp_n     = 1'b0;
      rt_n     = 1'b0;
      ps_n     = 1'b0;
      pp_n     = 1'b0;
      pt_n     = 1'b0;
      lat_rec  = 1'b0;
      lat_play = 1'b0;
      lat_mode = 1'b0;
      len_we   = 1'b0;
      unique case (state_q)
         S_INIT: begin
            if (!i2c_sent_q)
               i2c_n = 1'b1;
            else if (i_i2c_fin)
               state_n = S_IDLE;
         end
         S_IDLE: begin
            if (rec_e) begin
               lat_rec = 1'b1;
               rs_n    = 1'b1;
               state_n = S_RECD;
            end else if (play_e) begin
               lat_play = 1'b1;
               lat_mode = 1'b1;
               if (len_sel != '0) begin
                  ps_n    = 1'b1;
                  state_n = S_PLAY;
               end
            end
         end
         S_RECD: begin
            if (stop_e || i_rec_addr == end_q) begin
               rt_n    = 1'b1;
               len_we  = 1'b1;
               state_n = S_IDLE;
            end else if (rec_e) begin
               rp_n    = 1'b1;
               state_n = S_RECD_P;
            end
         end
         S_RECD_P: begin
            if (stop_e) begin
               rt_n    = 1'b1;
               len_we  = 1'b1;
               state_n = S_IDLE;
            end else if (rec_e) begin
               rs_n    = 1'b1;
               state_n = S_RECD;
            end
         end
         S_PLAY: begin
            if (stop_e || i_play_addr >= end_q) begin
               pt_n    = 1'b1;
               state_n = S_IDLE;
            end else if (play_e) begin
               pp_n    = 1'b1;
               state_n = S_PLAY_P;
            end
         end
         S_PLAY_P: begin
            if (stop_e) begin
               pt_n    = 1'b1;
               state_n = S_IDLE;
            end else if (play_e) begin
               ps_n     = 1'b1;
               lat_mode = 1'b1;
               state_n  = S_PLAY;
            end
         end
         default: state_n = S_INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         key_rec_q     <= 1'b0;
         key_play_q    <= 1'b0;
         key_stop_q    <= 1'b0;
         i2c_sent_q    <= 1'b0;
         o_i2c_start   <= 1'b0;
         o_rec_start   <= 1'b0;
         o_rec_pause   <= 1'b0;
         o_rec_stop    <= 1'b0;
         o_play_start  <= 1'b0;
         o_play_pause  <= 1'b0;
         o_play_stop   <= 1'b0;
         o_play_en     <= 1'b0;
         o_rec_active  <= 1'b0;
         slot_q        <= '0;
         base_q        <= '0;
         end_q         <= '0;
         o_speed       <= 4'd0;
         o_fast        <= 1'b0;
         o_slow_linear <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++)
            len_q[i] <= '0;
      end else begin
         key_rec_q    <= i_key_rec;
         key_play_q   <= i_key_play;
         key_stop_q   <= i_key_stop;
         i2c_sent_q   <= i2c_sent_q | i2c_n;
         o_i2c_start  <= i2c_n;
         o_rec_start  <= rs_n;
         o_rec_pause  <= rp_n;
         o_rec_stop   <= rt_n;
         o_play_start <= ps_n;
         o_play_pause <= pp_n;
         o_play_stop  <= pt_n;
         o_play_en    <= (state_n == S_PLAY);
         o_rec_active <= (state_n == S_RECD);
         if (lat_rec || lat_play) begin
            slot_q <= slot_m;
            base_q <= base_d;
            end_q  <= lat_rec ? (base_d | REG_LAST) : (base_d + len_sel);
         end
         if (lat_mode) begin
            o_speed       <= spd_c;
            o_fast        <= i_fast;
            o_slow_linear <= i_interp;
         end
         if (len_we)
            len_q[slot_q] <= i_rec_addr - base_q;
      end
   end

`ifdef AUD_XPORT_TIMER_EN
   localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);

   logic [PW-1:0] pre_q;
   logic [5:0]    sec_q;

   // Prescaler runs only while media is moving; pause states hold it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_q <= '0;
         sec_q <= 6'd0;
      end else if (state_q == S_IDLE &&
                   (state_n == S_RECD || state_n == S_PLAY)) begin
         pre_q <= '0;
         sec_q <= 6'd0;
      end else if (state_q == S_RECD || state_q == S_PLAY) begin
         if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            if (sec_q != 6'd63)
               sec_q <= sec_q + 6'd1;
         end else begin
            pre_q <= pre_q + PW'(1);
         end
      end
   end

   assign o_time_sec = sec_q;
`else
   assign o_time_sec = 6'd0;
`endif

endmodule

// File: tb/tb_aud_xport_ctrl.sv
// tb_aud_xport_ctrl: directed plan steps, then random keys/addresses
// checked every cycle against a transport-level reference model.
module tb_aud_xport_ctrl;

   localparam int unsigned MASK = 32'hFFFFF;
   localparam int unsigned REG  = 32'h40000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_rec = 0, key_play = 0, key_stop = 0;
   logic [1:0]  slot_sel = 0;
   logic [3:0]  speed = 0;
   logic        fast = 0, interp = 0, i2c_fin = 0;
   logic [19:0] rec_addr = 0, play_addr = 0;

   logic        i2c_start, rec_start, rec_pause, rec_stop;
   logic        play_start, play_pause, play_stop, play_en, rec_active;
   logic [19:0] base_addr, end_addr;
   logic [3:0]  o_speed;
   logic        o_fast, slow_linear;
   logic [2:0]  state;
   logic [5:0]  time_sec;

   int checks = 0;
   int failures = 0;

   aud_xport_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
      .i_slot_sel(slot_sel), .i_speed(speed), .i_fast(fast),
      .i_interp(interp), .i_i2c_fin(i2c_fin),
      .i_rec_addr(rec_addr), .i_play_addr(play_addr),
      .o_i2c_start(i2c_start), .o_rec_start(rec_start),
      .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
      .o_play_start(play_start), .o_play_pause(play_pause),
      .o_play_stop(play_stop), .o_play_en(play_en),
      .o_rec_active(rec_active), .o_base_addr(base_addr),
      .o_end_addr(end_addr), .o_speed(o_speed), .o_fast(o_fast),
      .o_slow_linear(slow_linear), .o_state(state), .o_time_sec(time_sec)
   );

   always #5 clk = ~clk;

   // Reference model: transport mode, slot table and expected pulses.
   int          m_mode;
   bit          m_started;
   bit          m_pr, m_pp, m_ps;
   int unsigned m_len [4];
   int unsigned m_slot, m_base, m_end;
   int unsigned m_spd;
   bit          m_fast, m_lin;
   bit          e_i2c, e_rs, e_rp, e_rt, e_ps, e_pp, e_pt;

   task automatic model_reset();
      m_mode = 0; m_started = 0;
      m_pr = 0; m_pp = 0; m_ps = 0;
      foreach (m_len[i]) m_len[i] = 0;
      m_slot = 0; m_base = 0; m_end = 0;
      m_spd = 0; m_fast = 0; m_lin = 0;
      {e_i2c, e_rs, e_rp, e_rt, e_ps, e_pp, e_pt} = '0;
   endtask

   task automatic latch_mode();
      if (speed == 0) m_spd = 1;
      else if (speed > 8) m_spd = 8;
      else m_spd = speed;
      m_fast = fast;
      m_lin = interp;
   endtask

   task automatic end_rec();
      e_rt = 1;
      m_len[m_slot] = (rec_addr - m_base) & MASK;
      m_mode = 1;
   endtask

   task automatic model_step();
      bit re, pe, se;
      re = key_rec && !m_pr;
      pe = key_play && !m_pp;
      se = key_stop && !m_ps;
      m_pr = key_rec; m_pp = key_play; m_ps = key_stop;
      {e_i2c, e_rs, e_rp, e_rt, e_ps, e_pp, e_pt} = '0;
      case (m_mode)
         0: if (!m_started) begin
               e_i2c = 1; m_started = 1;
            end else if (i2c_fin) m_mode = 1;
         1: if (re) begin
               m_slot = slot_sel;
               m_base = m_slot * REG;
               m_end = m_base + REG - 1;
               e_rs = 1; m_mode = 2;
            end else if (pe) begin
               m_slot = slot_sel;
               m_base = m_slot * REG;
               m_end = (m_base + m_len[m_slot]) & MASK;
               latch_mode();
               if (m_len[m_slot] != 0) begin
                  e_ps = 1; m_mode = 4;
               end
            end
         2: if (se || rec_addr == m_end) end_rec();
            else if (re) begin e_rp = 1; m_mode = 3; end
         3: if (se) end_rec();
            else if (re) begin e_rs = 1; m_mode = 2; end
         4: if (se || play_addr >= m_end) begin e_pt = 1; m_mode = 1; end
            else if (pe) begin e_pp = 1; m_mode = 5; end
         5: if (se) begin e_pt = 1; m_mode = 1; end
            else if (pe) begin e_ps = 1; latch_mode(); m_mode = 4; end
         default: ;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("state", state, m_mode);
      chk("i2c_start", i2c_start, e_i2c);
      chk("rec_start", rec_start, e_rs);
      chk("rec_pause", rec_pause, e_rp);
      chk("rec_stop", rec_stop, e_rt);
      chk("play_start", play_start, e_ps);
      chk("play_pause", play_pause, e_pp);
      chk("play_stop", play_stop, e_pt);
      chk("play_en", play_en, m_mode == 4);
      chk("rec_active", rec_active, m_mode == 2);
      chk("base_addr", base_addr, m_base);
      chk("end_addr", end_addr, m_end);
      chk("speed", o_speed, m_spd);
      chk("fast", o_fast, m_fast);
      chk("slow_linear", slow_linear, m_lin);
`ifndef AUD_XPORT_TIMER_EN
      chk("time_sec", time_sec, 0);
`endif
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int cnt;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      chk("reset_state", state, 0);

      // INIT: keys ignored, fin after 5 cycles
      rst_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         key_rec = (c == 2);
         key_play = (c == 3);
         cyc();
         if (c == 1) chk("i2c_pulse_c1", i2c_start, 1);
         if (c == 2) chk("i2c_pulse_c2", i2c_start, 0);
      end
      key_rec = 0; key_play = 0;
      i2c_fin = 1;
      cyc();
      chk("init_to_idle", state, 1);

      // record slot 2, stop at 0x80100
      slot_sel = 2; key_rec = 1;
      cyc();
      chk("rec2_start", rec_start, 1);
      chk("rec2_base", base_addr, 32'h80000);
      chk("rec2_active", rec_active, 1);
      key_rec = 0; rec_addr = 20'h80100; key_stop = 1;
      cyc();
      chk("rec2_stop", rec_stop, 1);
      key_stop = 0;
      cyc();

      // play slot 2, speed clamped, auto-stop at end
      speed = 12; fast = 1; play_addr = 20'h80000; key_play = 1;
      cyc();
      chk("play2_start", play_start, 1);
      chk("play2_speed", o_speed, 8);
      chk("play2_end", end_addr, 32'h80100);
      key_play = 0;
      cyc();
      play_addr = 20'h80100;
      cyc();
      chk("play2_autostop", play_stop, 1);
      chk("play2_idle", state, 1);

      // empty slot 1
      slot_sel = 1; key_play = 1;
      cyc();
      chk("empty_state", state, 1);
      chk("empty_nopulse", play_start, 0);
      key_play = 0;
      cyc();

      // speed 0 -> 1
      slot_sel = 2; speed = 0; play_addr = 20'h80000; key_play = 1;
      cyc();
      chk("speed0", o_speed, 1);
      key_play = 0; key_stop = 1;
      cyc();
      key_stop = 0;
      cyc();

      // full region with coincident stop
      slot_sel = 0; rec_addr = 0; key_rec = 1;
      cyc();
      key_rec = 0;
      cyc();
      rec_addr = 20'h3FFFF; key_stop = 1;
      cyc();
      chk("full_stop", rec_stop, 1);
      key_stop = 0; rec_addr = 0;
      cyc();
      chk("full_single", rec_stop, 0);
      play_addr = 0; key_play = 1;
      cyc();
      chk("full_len", end_addr, 32'h3FFFF);
      key_play = 0;
      cyc();
      key_play = 1;
      cyc();
      chk("play_paused", state, 5);
      key_play = 0;
      cyc();
      key_rec = 1; key_stop = 1;
      cyc();
      chk("pp_stop", play_stop, 1);
      chk("pp_no_rec", rec_start, 0);
      chk("pp_idle", state, 1);
      key_rec = 0; key_stop = 0;
      cyc();

      // held rec key
      slot_sel = 3; rec_addr = 0; key_rec = 1; cnt = 0;
      for (int c = 0; c < 100; c++) begin
         cyc();
         cnt += rec_start;
      end
      chk("held_pulses", cnt, 1);
      key_rec = 0; key_stop = 1;
      cyc();
      key_stop = 0;
      cyc();

      // random phase with one mid-run reset
      for (int n = 0; n < 800; n++) begin
         if (n == 400) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_all();
            @(negedge clk);
            check_all();
            rst_n = 1'b1;
         end
         key_rec  = ($urandom_range(0, 5) == 0);
         key_play = ($urandom_range(0, 5) == 0);
         key_stop = ($urandom_range(0, 9) == 0);
         slot_sel = 2'($urandom_range(0, 3));
         speed    = 4'($urandom_range(0, 15));
         fast     = 1'($urandom_range(0, 1));
         interp   = 1'($urandom_range(0, 1));
         i2c_fin  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 19) == 0)
            rec_addr = 20'(m_end);
         else
            rec_addr = 20'(m_base + $urandom_range(0, 255));
         play_addr = 20'(m_base + $urandom_range(0, 300));
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
